// File: rtl/sn74ls166_piso.sv
// rtl/sn74ls166_piso.sv - parallel-in/serial-out shift register with async clear and clock inhibit (74LS166)
// Optional macro SN74LS166_TIMING_EN adds typical qh delays and a short-clr-pulse warning.
`timescale 1ns/100ps
module sn74ls166_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clkinh,
    input  logic             sh_ld,
    input  logic             ser,
    input  logic [WIDTH-1:0] d,
    output logic             qh
);

    // r[WIDTH-1] is stage A (serial entry), r[0] is stage H (output)
    logic [WIDTH-1:0] r;

    // Unknown control values poison the whole register rather than guessing a mode
    always_ff @(posedge clk or negedge clr) begin
        if (clr === 1'b0) begin
            r <= '0;
        end else if (clr !== 1'b1) begin
            r <= 'x;
        end else if (clkinh === 1'b0) begin
            if (sh_ld === 1'b1) begin
                r <= {ser, r[WIDTH-1:1]};
            end else if (sh_ld === 1'b0) begin
                r <= d;
            end else begin
                r <= 'x;
            end
        end else if (clkinh !== 1'b1) begin
            r <= 'x;
        end
    end

`ifdef SN74LS166_TIMING_EN
    logic    qh_d;
    realtime clr_fall_t;

    always @(negedge clr) begin
        clr_fall_t = $realtime;
        qh_d <= #30 1'b0;
    end

    always @(posedge clr) begin
        if ($realtime - clr_fall_t < 20.0)
            $display("WARNING sn74ls166_piso: clr pulse shorter than 20 ns at %0t", $realtime);
    end

    // Clock-driven output changes use the rise/fall typicals of the part
    always @(r[0]) begin
        if (clr === 1'b1) begin
            if (r[0] === 1'b1)
                qh_d <= #21 1'b1;
            else
                qh_d <= #27 r[0];
        end
    end

    assign qh = qh_d;
`else
    assign qh = r[0];
`endif

endmodule

// File: tb/tb_sn74ls166_piso.sv
// tb/tb_sn74ls166_piso.sv - randomized and directed bench for a two-stage cascade of sn74ls166_piso
`timescale 1ns/100ps
module tb_sn74ls166_piso;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic         clkinh;
    logic         sh_ld;
    logic         ser;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         qh0;
    logic         qh1;

    int checks = 0;
    int errors = 0;

    // Chain model in output order: [0..W-1] is the far instance (H..A), [W..2W-1] the near one
    bit cq[$];

    always #5 clk = ~clk;

    sn74ls166_piso #(.WIDTH(W)) u0 (
        .clk(clk), .clr(clr), .clkinh(clkinh), .sh_ld(sh_ld),
        .ser(ser), .d(d0), .qh(qh0)
    );

    sn74ls166_piso #(.WIDTH(W)) u1 (
        .clk(clk), .clr(clr), .clkinh(clkinh), .sh_ld(sh_ld),
        .ser(qh0), .d(d1), .qh(qh1)
    );

    function automatic void model_clear();
        cq.delete();
        for (int i = 0; i < 2*W; i++) cq.push_back(1'b0);
    endfunction

    function automatic void model_load(input logic [W-1:0] a, input logic [W-1:0] b);
        cq.delete();
        for (int i = 0; i < W; i++) cq.push_back(b[i]);
        for (int i = 0; i < W; i++) cq.push_back(a[i]);
    endfunction

    function automatic void model_shift(input logic s);
        void'(cq.pop_front());
        cq.push_back(s);
    endfunction

    task automatic lit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: qh=%0b expected %0b", nm, $time, got, exp);
        end
    endtask

    task automatic step(input logic inh, input logic sl, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        clkinh = inh; sh_ld = sl; ser = s; d0 = a; d1 = b;
        @(posedge clk);
        if (!inh) begin
            if (!sl) model_load(a, b);
            else     model_shift(s);
        end
        #1;
    endtask

    task automatic clr_pulse(input string nm);
        clr = 1'b0;
        model_clear();
        #1;
        lit(nm, qh0, 1'b0);
        #1;
        clr = 1'b1;
    endtask

    always @(negedge clk) begin
        checks++;
        if (qh0 !== cq[W] || qh1 !== cq[0]) begin
            errors++;
            $display("FAIL model_cmp at %0t: qh0=%0b expected %0b, qh1=%0b expected %0b",
                     $time, qh0, cq[W], qh1, cq[0]);
        end
    end

    initial begin
        logic [W-1:0]   pat;
        logic [2*W-1:0] cat;
        model_clear();
        clr = 1'b0; clkinh = 1'b1; sh_ld = 1'b0; ser = 1'b0; d0 = '0; d1 = '0;
        #1;
        lit("reset", qh0, 1'b0);
        #1;
        clr = 1'b1;

        // Clear after a load of all ones
        step(0, 0, 0, 8'hFF, 8'h00);
        lit("preclear_load", qh0, 1'b1);
        clr_pulse("clear");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00, 8'h00);
            lit("clear_shift", qh0, 1'b0);
        end

        // Load and serialize
        pat = 8'b10110010;
        step(0, 0, 1, pat, 8'h00);
        lit("ser_load", qh0, 1'b0);
        for (int i = 1; i < W; i++) begin
            step(0, 1, 1, 8'h00, 8'h00);
            lit("ser_bit", qh0, pat[i]);
        end
        step(0, 1, 1, 8'h00, 8'h00);
        lit("ser_in", qh0, 1'b1);

        // Clock inhibit
        step(0, 0, 0, 8'h01, 8'h00);
        lit("inh_load", qh0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 8'h00, 8'h00);
            lit("inh_hold", qh0, 1'b1);
        end
        step(0, 1, 0, 8'h00, 8'h00);
        lit("inh_release", qh0, 1'b0);

        // Async clear mid-shift
        step(0, 0, 0, 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 8'h00);
        lit("mid_pre", qh0, 1'b1);
        clr_pulse("mid_clear");
        for (int i = 0; i < W; i++) begin
            step(0, 1, 0, 8'h00, 8'h00);
            lit("mid_shift", qh0, 1'b0);
        end

        // Reload during shift
        step(0, 0, 0, 8'hAA, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'h00, 8'h00);
        pat = 8'h55;
        step(0, 0, 0, pat, 8'h00);
        lit("reload", qh0, 1'b1);
        for (int i = 1; i < W; i++) begin
            step(0, 1, 0, 8'h00, 8'h00);
            lit("reload_bit", qh0, pat[i]);
        end

        // Cascade: far instance's qh emits F0 then 0F, LSB first, then zeros
        cat = {8'h0F, 8'hF0};
        step(0, 0, 0, 8'h0F, 8'hF0);
        lit("casc_load", qh1, cat[0]);
        for (int k = 1; k <= 2*W; k++) begin
            step(0, 1, 0, 8'h00, 8'h00);
            lit("casc_bit", qh1, (k < 2*W) ? cat[k] : 1'b0);
        end

        // Randomized traffic against the chain model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(19) == 0)
                clr_pulse("rand_clear");
            else
                step(($urandom_range(3) == 0), 1'($urandom), 1'($urandom),
                     W'($urandom), W'($urandom));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sn74ls166_piso.md
Name: sn74ls166_piso

Overview:
- Simulatable model of an 8-bit parallel-in/serial-out shift register with clear, after the 74LS166.
- It is the read-out counterpart of the parallel storage registers (sn74ls174 family). A word captured in parallel is loaded here and shifted out one bit per clock on QH.
- Used in serializer paths and cascaded chains; not intended to be synthesizable.

Parameters:
- WIDTH, 8, number of stages. The datasheet part is 8; other values are only for bench cascading studies.

Ports:
- clk  input  1  shift/load clock; active on rising edge
- clr  input  1  clear; asynchronous, active-low; forces all stages to 0
- clkinh  input  1  clock inhibit; high blocks clk edges
- sh_ld  input  1  mode select: 0 = parallel load, 1 = shift
- ser  input  1  serial data input into stage A
- d  input  WIDTH  parallel data; d[WIDTH-1] = A (first stage), d[0] = H (last stage)
- qh  output  1  last stage output (H)

Behaviour:
- Internal state: register r[WIDTH-1:0]. r[WIDTH-1] is stage A, r[0] is stage H. qh = r[0] at all times.
- Reset:
  - clr low drives r to all 0 and qh to 0 immediately, independent of clk, clkinh, sh_ld.
  - While clr is held low, clk edges are ignored.
  - clr release takes effect at once; the next qualifying rising clk edge operates normally.
- Qualifying edge: rising edge of clk with clkinh = 0 and clr = 1. clkinh is sampled at that edge. A clkinh transition alone never clocks the register.
- Load (sh_ld = 0 at a qualifying edge): r <= d. qh shows d[0] after the edge, latency 0 cycles.
- Shift (sh_ld = 1 at a qualifying edge): r <= {ser, r[WIDTH-1:1]}. Data moves A toward H; the old r[1] appears on qh.
- Hold: clkinh = 1 at the rising edge leaves r and qh unchanged.
- Serialization order:
  - After a load of d, the sequence is qh = d[0] at once, then d[1], ..., d[WIDTH-1] after WIDTH-1 shifts.
  - The following shifts deliver ser values in the order they were clocked in.
- Cascading: qh of one instance feeds ser of the next, giving a 2*WIDTH chain; no extra latency.
- X handling:
  - An x/z on sh_ld or clkinh at a qualifying edge sets r to all x.
  - An x on d during load, or on ser during shift, propagates only into the affected stages.
  - An x/z on clr sets r to x.
- Simultaneous events: clr falling at the same timestep as a clk rise resolves to clear, since clr has priority.
- Mode change between edges has no effect until the next qualifying edge.

Optional Feature:
- Macro: SN74LS166_TIMING_EN.
- Defined: qh changes carry datasheet typical delays under timescale 1ns/100ps:
  - clk to qh: tPLH 21 ns, tPHL 27 ns
  - clr to qh: tPHL 30 ns
  - A clr pulse shorter than 20 ns is flagged with a $display warning, and the clear still occurs.
- Undefined: all updates are zero-delay; no timing warnings.

Test Plan:
- Clear: clr=0 with clk=x, d=x, after a prior load of 8'hFF -> qh=0. The next 3 shifts with ser=0 and clr=1 keep qh=0.
- Load and serialize:
  - Stimulus: clr=1, sh_ld=0, d=8'b10110010, one rising clk -> qh=0.
  - Then sh_ld=1, ser=1, 7 rising clks -> qh sequence 1,0,0,1,1,0,1.
  - An 8th clk -> qh=1, the first bit taken in from ser.
- Inhibit: after loading d=8'h01 (qh=1), set clkinh=1 and apply 4 clk edges with sh_ld=1, ser=0 -> qh stays 1. With clkinh=0, one edge -> qh=0.
- Async clear mid-shift: load 8'hFF, shift 3 times, pulse clr low between edges -> qh=0 at once. The next 8 shifts with ser=0 give qh=0 throughout.
- Reload during shift: load 8'hAA, shift 2, set sh_ld=0 with d=8'h55 and one edge -> qh=1, and the subsequent shift sequence follows 8'h55 bit order.
- Cascade: two instances chained, load 8'h0F / 8'hF0, shift 16 with ser=0 -> qh shows 8 bits of 8'hF0 then 8'h0F, LSB first, then 0s.
